// File: rtl/rob.sv
// Reorder buffer: 32-entry circular buffer with 3-wide dispatch, completion and in-order retire.
// Way 2 is always the oldest instruction of a group, way 0 the youngest.
package rob_pkg;
    parameter int ROB  = 5;
    parameter int ROBW = 32;
    parameter int PR   = 6;
    parameter int XLEN = 32;

    typedef struct packed {
        logic            valid;
        logic [PR-1:0]   Tnew;
        logic [PR-1:0]   Told;
        logic [4:0]      arch_reg;
        logic            completed;
        logic            precise_state_need;
        logic [XLEN-1:0] target_pc;
        logic            halt;
    } rob_entry_t;
endpackage

module rob
    import rob_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset,
    input  rob_entry_t [2:0]          rob_in,
    input  logic [2:0]                complete_valid,
    input  logic [2:0][ROB-1:0]       complete_entry,
    input  logic [2:0]                precise_state_valid,
    input  logic [2:0][XLEN-1:0]      target_pc,
    input  logic                      BPRecoverEN,
    output logic [2:0][ROB-1:0]       dispatch_index,
    output rob_entry_t [2:0]          retire_entry,
    output logic [2:0]                struct_stall
`ifdef TEST_MODE
    ,
    output rob_entry_t [ROBW-1:0]     rob_entries_display,
    output logic [ROB-1:0]            head_display,
    output logic [ROB-1:0]            tail_display
`endif
);
    localparam int WAYS = 3;

    rob_entry_t           entries [ROBW];
    logic [ROB-1:0]       head, tail;
    logic [ROB:0]         count, free;
    logic [2:0][ROB-1:0]  retire_idx;
    rob_entry_t [2:0]     rd;
    logic [2:0]           dispatch_ok, retire_ok;
    logic [1:0]           n_disp, n_ret;

    // Free space uses registered count only; slots freed by this cycle's retire are not reused until next cycle.
    assign free = (ROB+1)'(ROBW) - count;

    always_comb begin
        struct_stall = 3'b000;
        if (free == '0)                struct_stall = 3'b111;
        else if (free == (ROB+1)'(1))  struct_stall = 3'b011;
        else if (free == (ROB+1)'(2))  struct_stall = 3'b001;
    end

    genvar w;
    generate
        for (w = 0; w < WAYS; w++) begin : g_way
            assign dispatch_index[w] = tail + ROB'(WAYS-1-w);
            assign retire_idx[w]     = head + ROB'(WAYS-1-w);
            assign dispatch_ok[w]    = rob_in[w].valid & ~struct_stall[w];
            assign rd[w]             = entries[retire_idx[w]];
        end
    endgenerate

    // Retire chain from the head; a recovery point or halt ends the group after itself.
    always_comb begin
        retire_ok    = '0;
        retire_entry = '0;
        retire_ok[2] = rd[2].valid & rd[2].completed;
        retire_ok[1] = retire_ok[2] & ~(rd[2].precise_state_need | rd[2].halt)
                       & rd[1].valid & rd[1].completed;
        retire_ok[0] = retire_ok[1] & ~(rd[1].precise_state_need | rd[1].halt)
                       & rd[0].valid & rd[0].completed;
        for (int i = 0; i < WAYS; i++)
            if (retire_ok[i]) retire_entry[i] = rd[i];
    end

    assign n_disp = 2'($countones(dispatch_ok));
    assign n_ret  = 2'($countones(retire_ok));

    always_ff @(posedge clock) begin
        if (reset || BPRecoverEN) begin
            for (int i = 0; i < ROBW; i++) entries[i] <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            for (int i = 0; i < WAYS; i++) begin
                if (complete_valid[i] && entries[complete_entry[i]].valid) begin
                    entries[complete_entry[i]].completed          <= 1'b1;
                    entries[complete_entry[i]].precise_state_need <= precise_state_valid[i];
                    entries[complete_entry[i]].target_pc          <= target_pc[i];
                end
            end
            // Dispatch targets free slots and retire targets occupied ones, so they never collide.
            for (int i = 0; i < WAYS; i++)
                if (dispatch_ok[i]) entries[dispatch_index[i]] <= rob_in[i];
            for (int i = 0; i < WAYS; i++)
                if (retire_ok[i]) entries[retire_idx[i]] <= '0;
            head  <= head + ROB'(n_ret);
            tail  <= tail + ROB'(n_disp);
            count <= count + (ROB+1)'(n_disp) - (ROB+1)'(n_ret);
        end
    end

`ifdef TEST_MODE
    genvar e;
    generate
        for (e = 0; e < ROBW; e++) begin : g_disp
            assign rob_entries_display[e] = entries[e];
        end
    endgenerate
    assign head_display = head;
    assign tail_display = tail;
`endif
endmodule

// File: tb/tb_rob.sv
// Bench for rob: directed vector table for the fill/complete/retire/flush story,
// then randomized traffic checked against a queue-style occupancy model.
module tb_rob;
    import rob_pkg::*;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    rob_entry_t [2:0]     rob_in;
    logic [2:0]           complete_valid;
    logic [2:0][ROB-1:0]  complete_entry;
    logic [2:0]           precise_state_valid;
    logic [2:0][XLEN-1:0] target_pc;
    logic                 BPRecoverEN;
    logic [2:0][ROB-1:0]  dispatch_index;
    rob_entry_t [2:0]     retire_entry;
    logic [2:0]           struct_stall;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    rob dut (
        .clock(clock), .reset(reset), .rob_in(rob_in),
        .complete_valid(complete_valid), .complete_entry(complete_entry),
        .precise_state_valid(precise_state_valid), .target_pc(target_pc),
        .BPRecoverEN(BPRecoverEN), .dispatch_index(dispatch_index),
        .retire_entry(retire_entry), .struct_stall(struct_stall)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Directed table
    typedef struct {
        logic [2:0]      disp;
        logic [2:0]      cv;
        logic [2:0][4:0] ce;
        logic [2:0]      psv;
        logic            rec;
        logic [2:0]      e_stall;
        logic [4:0]      e_di2;
        logic [2:0]      e_ret;
        logic [5:0]      e_told2;
        logic [31:0]     e_tpc1;
    } vec_t;
    vec_t vt[$];

    task automatic addv(input logic [2:0] disp, input logic [2:0] cv,
                        input int c2, input int c1, input int c0,
                        input logic [2:0] psv, input logic rec,
                        input logic [2:0] st, input int di2, input logic [2:0] ret,
                        input int told2, input int tpc1);
        vec_t v;
        v.disp = disp; v.cv = cv;
        v.ce[2] = 5'(c2); v.ce[1] = 5'(c1); v.ce[0] = 5'(c0);
        v.psv = psv; v.rec = rec; v.e_stall = st; v.e_di2 = 5'(di2);
        v.e_ret = ret; v.e_told2 = 6'(told2); v.e_tpc1 = 32'(tpc1);
        vt.push_back(v);
    endtask

    function automatic rob_entry_t mk(input logic v, input int seq);
        rob_entry_t e;
        e = '0;
        e.valid = v; e.Told = PR'(seq); e.Tnew = PR'(seq + 31); e.arch_reg = 5'(seq);
        return e;
    endfunction

    // Reference model: slots addressed by head + offset, occupancy as a plain integer
    rob_entry_t m_ent [32];
    int m_head, m_count;

    function automatic void m_retire(output rob_entry_t [2:0] r, output int n);
        rob_entry_t e;
        r = '0; n = 0;
        for (int i = 0; i < 3; i++) begin
            e = m_ent[(m_head + i) % 32];
            if (!(e.valid && e.completed)) break;
            r[2-i] = e; n++;
            if (e.precise_state_need || e.halt) break;
        end
    endfunction

    function automatic logic [2:0] m_stall();
        logic [2:0] s;
        for (int k = 0; k < 3; k++) s[k] = ((2 - k) >= (32 - m_count));
        return s;
    endfunction

    task automatic m_step(input logic rst, input logic rec);
        rob_entry_t [2:0] r;
        int nret, tl, fr, wr;
        if (rst || rec) begin
            for (int i = 0; i < 32; i++) m_ent[i] = '0;
            m_head = 0; m_count = 0;
            return;
        end
        m_retire(r, nret);
        for (int k = 0; k < 3; k++)
            if (complete_valid[k] && m_ent[complete_entry[k]].valid) begin
                m_ent[complete_entry[k]].completed          = 1'b1;
                m_ent[complete_entry[k]].precise_state_need = precise_state_valid[k];
                m_ent[complete_entry[k]].target_pc          = target_pc[k];
            end
        for (int i = 0; i < nret; i++) m_ent[(m_head + i) % 32] = '0;
        tl = (m_head + m_count) % 32; fr = 32 - m_count; wr = 0;
        for (int k = 2; k >= 0; k--)
            if (rob_in[k].valid && (2 - k) < fr) begin
                m_ent[(tl + 2 - k) % 32] = rob_in[k];
                wr++;
            end
        m_head  = (m_head + nret) % 32;
        m_count = m_count + wr - nret;
    endtask

    initial begin
        rob_entry_t [2:0] er;
        rob_entry_t e;
        int nr, tl, nd;
        logic [2:0][4:0] edi;

        rob_in = '0; complete_valid = '0; complete_entry = '0;
        precise_state_valid = '0; target_pc = '0; BPRecoverEN = 1'b0;

        // disp cv ce2 ce1 ce0 psv rec | stall di2 ret told2 tpc1
        addv(3'b000, 3'b000, 0, 0, 0, 3'b000, 0, 3'b000, 0, 3'b000, 0, 0);
        for (int j = 0; j <= 10; j++)
            addv(3'b111, 3'b000, 0, 0, 0, 3'b000, 0, (j == 10) ? 3'b001 : 3'b000,
                 (3 * j) % 32, 3'b000, 0, 0);
        addv(3'b111, 3'b000, 0, 0, 0, 3'b000, 0, 3'b111, 0, 3'b000, 0, 0);
        addv(3'b000, 3'b000, 0, 0, 0, 3'b000, 0, 3'b111, 0, 3'b000, 0, 0);
        addv(3'b000, 3'b111, 0, 1, 2, 3'b010, 0, 3'b111, 0, 3'b000, 0, 0);
        addv(3'b000, 3'b000, 0, 0, 0, 3'b000, 0, 3'b111, 0, 3'b110, 1, 32);
        addv(3'b000, 3'b111, 3, 4, 5, 3'b000, 0, 3'b001, 0, 3'b100, 3, 0);
        addv(3'b000, 3'b000, 0, 0, 0, 3'b000, 0, 3'b000, 0, 3'b111, 4, 32);
        addv(3'b000, 3'b100, 7, 0, 0, 3'b000, 0, 3'b000, 0, 3'b000, 0, 0);
        addv(3'b000, 3'b000, 0, 0, 0, 3'b000, 0, 3'b000, 0, 3'b000, 0, 0);
        addv(3'b000, 3'b100, 6, 0, 0, 3'b000, 0, 3'b000, 0, 3'b000, 0, 0);
        addv(3'b000, 3'b000, 0, 0, 0, 3'b000, 0, 3'b000, 0, 3'b110, 7, 32);
        addv(3'b111, 3'b111, 8, 9, 10, 3'b000, 1, 3'b000, 0, 3'b000, 0, 0);
        addv(3'b000, 3'b000, 0, 0, 0, 3'b000, 0, 3'b000, 0, 3'b000, 0, 0);
        addv(3'b100, 3'b000, 0, 0, 0, 3'b000, 0, 3'b000, 0, 3'b000, 0, 0);
        addv(3'b000, 3'b100, 0, 0, 0, 3'b000, 0, 3'b000, 1, 3'b000, 0, 0);
        addv(3'b000, 3'b000, 0, 0, 0, 3'b000, 0, 3'b000, 1, 3'b100, (3 * 23 + 1) % 64, 0);

        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        for (int i = 0; i < vt.size(); i++) begin
            for (int k = 0; k < 3; k++) begin
                rob_in[k]    = mk(vt[i].disp[k], 3 * (i - 1) + 1 + (2 - k));
                target_pc[k] = 32;
            end
            complete_valid = vt[i].cv; complete_entry = vt[i].ce;
            precise_state_valid = vt[i].psv; BPRecoverEN = vt[i].rec;
            #1;
            edi[2] = vt[i].e_di2; edi[1] = vt[i].e_di2 + 5'd1; edi[0] = vt[i].e_di2 + 5'd2;
            chk($sformatf("v%0d stall", i), 64'(struct_stall), 64'(vt[i].e_stall));
            chk($sformatf("v%0d dindex", i), 64'(dispatch_index), 64'(edi));
            chk($sformatf("v%0d retmask", i),
                64'({retire_entry[2].valid, retire_entry[1].valid, retire_entry[0].valid}),
                64'(vt[i].e_ret));
            chk($sformatf("v%0d told2", i), 64'(retire_entry[2].Told), 64'(vt[i].e_told2));
            chk($sformatf("v%0d tpc1", i), 64'(retire_entry[1].target_pc), 64'(vt[i].e_tpc1));
            if (vt[i].e_ret[1])
                chk($sformatf("v%0d psn1", i), 64'(retire_entry[1].precise_state_need),
                    64'(i == 15));
            for (int k = 0; k < 3; k++)
                if (!vt[i].e_ret[k])
                    chk($sformatf("v%0d zero%0d", i, k), 64'(retire_entry[k]), 64'd0);
            @(posedge clock);
            #1;
        end

        // Randomized traffic; first cycle holds reset together with flush/dispatch/completion.
        for (int i = 0; i < 32; i++) m_ent[i] = '0;
        m_head = 0; m_count = 0;
        for (int c = 0; c < 1500; c++) begin
            reset       = (c == 0) || ($urandom % 200 == 0);
            BPRecoverEN = (c == 0) || ($urandom % 60 == 0);
            nd = $urandom % 4;
            for (int k = 0; k < 3; k++) begin
                e = '0;
                e.valid = ((2 - k) < nd);
                e.Tnew = PR'($urandom); e.Told = PR'($urandom); e.arch_reg = 5'($urandom);
                e.completed = ($urandom % 5 == 0);
                e.precise_state_need = e.completed && ($urandom % 4 == 0);
                e.halt = ($urandom % 20 == 0);
                e.target_pc = $urandom;
                rob_in[k] = e;
                complete_valid[k] = $urandom % 2;
                complete_entry[k] = ($urandom % 8 == 0) ? 5'($urandom)
                                                        : 5'((m_head + $urandom_range(0, 6)) % 32);
                precise_state_valid[k] = ($urandom % 6 == 0);
                target_pc[k] = $urandom;
            end
            #1;
            if (c > 0) begin
                m_retire(er, nr);
                tl = (m_head + m_count) % 32;
                for (int k = 0; k < 3; k++) edi[k] = 5'((tl + 2 - k) % 32);
                chk($sformatf("r%0d stall", c), 64'(struct_stall), 64'(m_stall()));
                chk($sformatf("r%0d dindex", c), 64'(dispatch_index), 64'(edi));
                for (int k = 0; k < 3; k++)
                    chk($sformatf("r%0d ret%0d", c, k), 64'(retire_entry[k]), 64'(er[k]));
            end
            @(posedge clock);
            #1;
            m_step(reset, BPRecoverEN);
        end
        reset = 1'b0; BPRecoverEN = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
